gray_seq_ctrl: RTL and testbench
================================

Name: gray_seq_ctrl

Overview:
Sequencer that drives the binary-to-Gray conversion stage. It owns a W-bit binary step counter and advances it one code per clock while running. It presents the counter value and the registered Gray code (G[i] = B[i+1] xor B[i], MSB passed through) together with a VALID strobe. It supports free-run (wrap) and single-sweep modes, up/down direction, pause/resume and preload, so downstream logic can be stepped through Gray sequences under control.

Parameters:
W, 4, counter and Gray code width (minimum 2)

Ports:
CLK  input  1  single clock, rising edge
RSTN  input  1  asynchronous, active-low reset
START  input  1  start from IDLE, or resume from PAUSE
STOP  input  1  pause from RUN, or abort from PAUSE
DIR  input  1  0 = count up, 1 = count down; sampled every RUN cycle
MODE  input  1  0 = free-run with wrap, 1 = single sweep to terminal
LOAD  input  1  preload B from D; honoured only in IDLE or PAUSE
D  input  W  binary preload value
B  output  W  registered binary count
G  output  W  registered Gray code of B
VALID  output  1  one-cycle pulse after each counting step
BUSY  output  1  high in RUN and PAUSE
DONE  output  1  one-cycle pulse when a sweep completes

Behaviour:
- Reset (RSTN = 0, asynchronous): B = 0, G = 0, VALID = 0, DONE = 0, BUSY = 0, state = IDLE.
- G is registered and computed from next-B, so G always equals gray(B) with zero relative latency.
- States: IDLE, RUN, PAUSE. BUSY is derived from the registered state.
- IDLE:
  - LOAD: B <= D.
  - START: go to RUN at that edge. LOAD and START together means the load applies and the count starts from D.
  - STOP: ignored.
- RUN:
  - Each edge: B <= B + 1 (DIR = 0) or B - 1 (DIR = 1), modulo 2^W; VALID = 1 in the following cycle.
  - LOAD is ignored.
  - STOP: go to PAUSE; no step on that edge. STOP has priority over START.
- PAUSE:
  - B and G hold.
  - LOAD: B <= D.
  - START alone: go to RUN.
  - STOP: go to IDLE (abort, no DONE, B retained).
- Latency: START sampled at edge k gives state RUN after k. The first B change happens at edge k+1, and VALID is high during cycle k+1..k+2.
- Free-run (MODE = 0): wraps all-ones -> 0 going up and 0 -> all-ones going down. Runs until STOP.
- Sweep (MODE = 1):
  - Terminal value is all-ones going up and 0 going down.
  - On the edge where B becomes terminal: state -> IDLE; VALID and DONE both pulse in the next cycle.
  - If START arrives while B already equals terminal for the current DIR: no step, no VALID; DONE pulses one cycle later and state returns to IDLE.
- DIR changes during RUN take effect on the next step. The terminal value follows the current DIR.
- MODE is sampled every RUN cycle. Switching to 0 mid-sweep continues as free-run.
- Reset mid-run: immediate return to reset values; no DONE.

Decomposition:
- Shared package: state encoding constants (IDLE, RUN, PAUSE, 2-bit) and a bin-to-Gray function of width W.
- One natural sub-module, gray_conv (combinational W-bit binary-to-Gray xor chain). It is instantiated on next-B ahead of the G register.

Test Plan:
- Reset and idle: RSTN low mid-count, then high -> B = 0, G = 0, VALID = 0, DONE = 0, BUSY = 0; START/STOP absent -> outputs hold.
- Free-run up from 0 (W = 4, MODE = 0): G sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, then wraps to 0 with VALID every cycle; the first change is one cycle after START.
- Sweep down with preload: LOAD D = 5 plus START, MODE = 1, DIR = 1 -> B 4,3,2,1,0; G 6,2,3,1,0; DONE pulses once with the last VALID; BUSY drops; B stays 0.
- Sweep at terminal: B = 15, MODE = 1, DIR = 0, START -> no VALID, DONE one cycle later, B = 15.
- Pause/resume/abort: STOP at B = 3 -> B holds 3, BUSY = 1, LOAD D = 9 accepted; START -> B continues 10, 11; STOP twice -> IDLE, no DONE; START and STOP together in RUN -> PAUSE.
- Direction flip mid-run: counting up at B = 7, DIR -> 1 -> next B values 6, 5 (G 5, 7); LOAD asserted during RUN -> ignored.

Source files
------------

// File: rtl/gray_seq_ctrl_pkg.sv
// Shared types and helpers for the Gray-code sequencer.
package gray_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } state_e;

  localparam int unsigned MaxW = 32;

  // Reference conversion for callers that work at the maximum width.
  function automatic logic [MaxW-1:0] bin2gray(input logic [MaxW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_conv.sv
// Combinational W-bit binary-to-Gray conversion; the MSB passes straight through.
module gray_conv #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_seq_ctrl.sv
// Step-counter sequencer presenting a binary count and its registered Gray code.
module gray_seq_ctrl
  import gray_seq_ctrl_pkg::*;
#(
  parameter int unsigned W = 4  // minimum 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic         dir,
  input  logic         mode,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] b,
  output logic [W-1:0] g,
  output logic         valid,
  output logic         busy,
  output logic         done
);

  state_e       state_q, state_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] g_q, g_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;
  logic [W-1:0] term;
  logic [W-1:0] step;

  assign term = dir ? '0 : '1;
  assign step = dir ? (b_q - W'(1)) : (b_q + W'(1));

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) b_d = d;
        if (start) state_d = StRun;
      end
      StRun: begin
        if (stop) begin
          state_d = StPause;
        end else if (mode && (b_q == term)) begin
          // Sweep started at its terminal value: finish without stepping.
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          b_d     = step;
          valid_d = 1'b1;
          if (mode && (step == term)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      StPause: begin
        if (load) b_d = d;
        if (stop) state_d = StIdle;
        else if (start) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  // Gray is taken from next-B so it never lags the registered count.
  gray_conv #(
    .W(W)
  ) u_gray_conv (
    .bin  (b_d),
    .gray (g_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      b_q     <= '0;
      g_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      g_q     <= g_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign b     = b_q;
  assign g     = g_q;
  assign valid = valid_q;
  assign done  = done_q;
  assign busy  = (state_q == StRun) || (state_q == StPause);

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed-vector bench for gray_seq_ctrl at W = 4.
module tb_gray_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, dir, mode, load;
  logic [3:0] d;
  logic [3:0] b, g;
  logic       valid, busy, done;

  int total = 0;
  int bad   = 0;

  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
  logic [3:0] sb [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
  logic [3:0] sg [5] = '{4'h6, 4'h2, 4'h3, 4'h1, 4'h0};

  gray_seq_ctrl #(
    .W(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .dir   (dir),
    .mode  (mode),
    .load  (load),
    .d     (d),
    .b     (b),
    .g     (g),
    .valid (valid),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; d = '0;
    tick(); tick();
    chk("rst_b", b, 0); chk("rst_g", g, 0); chk("rst_valid", valid, 0);
    chk("rst_done", done, 0); chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_b", b, 0); chk("idle_busy", busy, 0); chk("idle_valid", valid, 0);

    // Free-run up from 0 with wrap
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fr0_b", b, 0); chk("fr0_valid", valid, 0); chk("fr0_busy", busy, 1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("fr_b", b, i % 16); chk("fr_g", g, gtab[i % 16]);
      chk("fr_valid", valid, 1); chk("fr_busy", busy, 1);
    end
    tick(); tick();
    chk("fr_pre_rst_b", b, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_b", b, 0); chk("midrst_g", g, 0); chk("midrst_valid", valid, 0);
    chk("midrst_busy", busy, 0); chk("midrst_done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_b", b, 0); chk("postrst_busy", busy, 0);

    // Sweep down from preload 5
    load = 1'b1; d = 4'd5; start = 1'b1; mode = 1'b1; dir = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    chk("sw0_b", b, 5); chk("sw0_valid", valid, 0); chk("sw0_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sw_b", b, sb[i]); chk("sw_g", g, sg[i]); chk("sw_valid", valid, 1);
      chk("sw_done", done, (i == 4) ? 1 : 0); chk("sw_busy", busy, (i == 4) ? 0 : 1);
    end
    tick();
    chk("swend_b", b, 0); chk("swend_valid", valid, 0); chk("swend_done", done, 0);

    // Sweep started at terminal
    load = 1'b1; d = 4'd15;
    tick();
    load = 1'b0; dir = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("term0_b", b, 15); chk("term0_busy", busy, 1); chk("term0_done", done, 0);
    tick();
    chk("term1_valid", valid, 0); chk("term1_done", done, 1);
    chk("term1_b", b, 15); chk("term1_busy", busy, 0);
    tick();
    chk("term2_done", done, 0); chk("term2_b", b, 15);

    // Pause, reload, resume, abort
    mode = 1'b0; load = 1'b1; d = 4'd0; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    tick(); tick(); tick();
    chk("pr_b3", b, 3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("pause_b", b, 3); chk("pause_valid", valid, 0); chk("pause_busy", busy, 1);
    tick();
    chk("pause_hold_b", b, 3); chk("pause_hold_g", g, 4'h2);
    load = 1'b1; d = 4'd9;
    tick();
    load = 1'b0;
    chk("pause_load_b", b, 9); chk("pause_load_g", g, 4'hD); chk("pause_load_busy", busy, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("resume_b", b, 9);
    tick();
    chk("resume_b10", b, 10); chk("resume_valid", valid, 1);
    tick();
    chk("resume_b11", b, 11);
    stop = 1'b1;
    tick();
    chk("stop1_busy", busy, 1); chk("stop1_b", b, 11);
    tick();
    stop = 1'b0;
    chk("abort_busy", busy, 0); chk("abort_done", done, 0); chk("abort_b", b, 11);
    start = 1'b1;
    tick();
    stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("both_busy", busy, 1); chk("both_b", b, 11); chk("both_valid", valid, 0);
    tick();
    chk("both_hold_b", b, 11);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("both_idle", busy, 0);

    // Direction flip mid-run; LOAD ignored while running
    load = 1'b1; d = 4'd5; dir = 1'b0; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    tick(); tick();
    chk("flip_b7", b, 7); chk("flip_g7", g, 4'h4);
    dir = 1'b1; load = 1'b1; d = 4'd0;
    tick();
    chk("flip_b6", b, 6); chk("flip_g6", g, 4'h5);
    tick();
    load = 1'b0;
    chk("flip_b5", b, 5); chk("flip_g5", g, 4'h7); chk("flip_valid", valid, 1);
    stop = 1'b1;
    tick(); tick();
    stop = 1'b0;
    chk("final_busy", busy, 0); chk("final_b", b, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
